// File: rtl/wb_conbus_rr.sv
// Wishbone shared-bus interconnect: NM masters, NS slaves, round-robin arbitration,
// upper-address-bit decode, ERR for unmapped addresses and a no-response watchdog.
module wb_conbus_rr #(
  parameter int unsigned               NM      = 2,
  parameter int unsigned               NS      = 6,
  parameter int unsigned               ADDR_W  = 3,
  parameter logic [NS*ADDR_W-1:0]      S_ADDR  = {3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd0},
  parameter int unsigned               TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  // master side
  input  logic [NM*32-1:0]  m_adr_i,
  input  logic [NM*32-1:0]  m_dat_i,
  input  logic [NM*4-1:0]   m_sel_i,
  input  logic [NM-1:0]     m_we_i,
  input  logic [NM-1:0]     m_cyc_i,
  input  logic [NM-1:0]     m_stb_i,
  output logic [31:0]       m_dat_o,
  output logic [NM-1:0]     m_ack_o,
  output logic [NM-1:0]     m_err_o,
  // slave side
  output logic [31:0]       s_adr_o,
  output logic [31:0]       s_dat_o,
  output logic [3:0]        s_sel_o,
  output logic              s_we_o,
  output logic [NS-1:0]     s_cyc_o,
  output logic [NS-1:0]     s_stb_o,
  input  logic [NS*32-1:0]  s_dat_i,
  input  logic [NS-1:0]     s_ack_i,
  input  logic [NS-1:0]     s_err_i,
  // debug
  output logic [NM-1:0]     grant_o,
  output logic              timeout_o
);

  localparam int unsigned IdxW       = (NM > 1) ? $clog2(NM) : 1;
  localparam int unsigned SIdxW      = (NS > 1) ? $clog2(NS) : 1;
  localparam bit          WdEn       = (TIMEOUT != 0);
  localparam logic [15:0] TimeoutVal = 16'(TIMEOUT);

  typedef enum logic [0:0] {StIdle, StOwned} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] owner_q, owner_d;
  logic [IdxW-1:0] last_q, last_d;
  logic [NM-1:0]   grant_q, grant_d;

  logic            err_q, err_d;
  logic            unm_done_q, unm_done_d;
  logic [15:0]     cnt_q, cnt_d;

  logic            own_cyc, own_stb, own_we;
  logic [31:0]     own_adr, own_dat;
  logic [3:0]      own_sel;

  logic             hit;
  logic [SIdxW-1:0] sidx;

  logic sl_ack, sl_err, int_err, resp, fire;

  // Arbiter: round-robin pick from last+1 while idle, hold until the owner drops cyc.
  always_comb begin
    logic [IdxW-1:0] cand;
    logic            found;
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    grant_d = grant_q;
    found   = 1'b0;
    cand    = '0;
    unique case (state_q)
      StIdle: begin
        if (|m_cyc_i) begin
          for (int unsigned k = 1; k <= NM; k++) begin
            cand = IdxW'((32'(last_q) + k) % NM);
            if (!found && m_cyc_i[cand]) begin
              found   = 1'b1;
              owner_d = cand;
            end
          end
          grant_d          = '0;
          grant_d[owner_d] = 1'b1;
          last_d           = owner_d;
          state_d          = StOwned;
        end
      end
      StOwned: begin
        if (!m_cyc_i[owner_q]) begin
          grant_d = '0;
          state_d = StIdle;
        end
      end
      default: begin
        grant_d = '0;
        state_d = StIdle;
      end
    endcase
  end

  // Owner's bus signals, all zero while nobody holds the grant.
  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    own_we  = 1'b0;
    own_adr = '0;
    own_dat = '0;
    own_sel = '0;
    if (state_q == StOwned) begin
      own_cyc = m_cyc_i[owner_q];
      own_stb = m_cyc_i[owner_q] & m_stb_i[owner_q];
      own_we  = m_we_i[owner_q];
      own_adr = m_adr_i[owner_q*32 +: 32];
      own_dat = m_dat_i[owner_q*32 +: 32];
      own_sel = m_sel_i[owner_q*4 +: 4];
    end
  end

  // Address decode; scanning downward lets the lowest matching slave win.
  always_comb begin
    hit  = 1'b0;
    sidx = '0;
    for (int j = int'(NS) - 1; j >= 0; j--) begin
      if (own_adr[31 -: ADDR_W] == S_ADDR[j*ADDR_W +: ADDR_W]) begin
        hit  = 1'b1;
        sidx = SIdxW'(j);
      end
    end
  end

  // Slave strobes, response routing and watchdog expiry.
  always_comb begin
    s_cyc_o = '0;
    s_stb_o = '0;
    m_dat_o = '0;
    m_ack_o = '0;
    m_err_o = '0;
    s_adr_o = own_adr;
    s_dat_o = own_dat;
    s_sel_o = own_sel;
    s_we_o  = own_we;
    sl_ack  = 1'b0;
    sl_err  = 1'b0;
    if (hit) begin
      s_cyc_o[sidx] = own_cyc;
      s_stb_o[sidx] = own_stb;
      // Gating with own_cyc keeps late acks of an aborted cycle from being routed.
      sl_ack        = own_cyc & s_ack_i[sidx];
      sl_err        = own_cyc & s_err_i[sidx];
      if (state_q == StOwned) begin
        m_dat_o = s_dat_i[sidx*32 +: 32];
      end
    end
    int_err = err_q & own_cyc;
    resp    = sl_ack | sl_err | int_err;
    // A slave ack in the expiry cycle suppresses the forced error.
    fire    = WdEn & own_stb & ~resp & (cnt_q == TimeoutVal);
    m_ack_o[owner_q] = sl_ack;
    m_err_o[owner_q] = sl_err | int_err | fire;
  end

  assign grant_o   = grant_q;
  assign timeout_o = fire;

  // Unmapped-address responder and watchdog next state.
  always_comb begin
    logic unm;
    unm = own_stb & ~hit;
    // One ERR per strobe: unm_done blocks repeats until stb drops or the address maps.
    err_d      = unm & ~err_q & ~unm_done_q;
    unm_done_d = unm & (unm_done_q | err_q);
    if (!WdEn || !own_stb || resp || fire) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      owner_q    <= '0;
      last_q     <= IdxW'(NM - 1);
      grant_q    <= '0;
      err_q      <= 1'b0;
      unm_done_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      grant_q    <= grant_d;
      err_q      <= err_d;
      unm_done_q <= unm_done_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_wb_conbus_rr.sv
// Directed bench for wb_conbus_rr: decode table plus arbitration, error and watchdog sequences.
module tb_wb_conbus_rr;

  logic         clk = 1'b0;
  logic         reset;
  logic [63:0]  m_adr_i, m_dat_i;
  logic [7:0]   m_sel_i;
  logic [1:0]   m_we_i, m_cyc_i, m_stb_i;
  logic [31:0]  m_dat_o;
  logic [1:0]   m_ack_o, m_err_o;
  logic [31:0]  s_adr_o, s_dat_o;
  logic [3:0]   s_sel_o;
  logic         s_we_o;
  logic [5:0]   s_cyc_o, s_stb_o;
  logic [191:0] s_dat_i;
  logic [5:0]   s_ack_i, s_err_i;
  logic [1:0]   grant_o;
  logic         timeout_o;

  int checks   = 0;
  int failures = 0;

  wb_conbus_rr #(
    .NM     (2),
    .NS     (6),
    .ADDR_W (3),
    .S_ADDR ({3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd0}),
    .TIMEOUT(8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .m_adr_i  (m_adr_i),
    .m_dat_i  (m_dat_i),
    .m_sel_i  (m_sel_i),
    .m_we_i   (m_we_i),
    .m_cyc_i  (m_cyc_i),
    .m_stb_i  (m_stb_i),
    .m_dat_o  (m_dat_o),
    .m_ack_o  (m_ack_o),
    .m_err_o  (m_err_o),
    .s_adr_o  (s_adr_o),
    .s_dat_o  (s_dat_o),
    .s_sel_o  (s_sel_o),
    .s_we_o   (s_we_o),
    .s_cyc_o  (s_cyc_o),
    .s_stb_o  (s_stb_o),
    .s_dat_i  (s_dat_i),
    .s_ack_i  (s_ack_i),
    .s_err_i  (s_err_i),
    .grant_o  (grant_o),
    .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] adr;
    logic        stb;
    logic [5:0]  ack;
    logic [5:0]  err;
    logic [5:0]  e_cyc;
    logic [5:0]  e_stb;
    logic [1:0]  e_ack;
    logic [1:0]  e_err;
    logic [31:0] e_dat;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  initial begin
    // Slave j answers with a recognisable word.
    vecs[0] = '{32'h0000_0010, 1'b1, 6'b000000, 6'b000000, 6'b000001, 6'b000001, 2'b00, 2'b00,
                32'hDEAD_BEEF};
    vecs[1] = '{32'h0000_0010, 1'b1, 6'b000001, 6'b000000, 6'b000001, 6'b000001, 2'b01, 2'b00,
                32'hDEAD_BEEF};
    vecs[2] = '{32'h4000_0000, 1'b1, 6'b000010, 6'b000000, 6'b000010, 6'b000010, 2'b01, 2'b00,
                32'h1111_1111};
    vecs[3] = '{32'h6000_0004, 1'b1, 6'b000001, 6'b000000, 6'b000100, 6'b000100, 2'b00, 2'b00,
                32'h2222_2222};
    vecs[4] = '{32'h8000_0000, 1'b1, 6'b000000, 6'b001000, 6'b001000, 6'b001000, 2'b00, 2'b01,
                32'h3333_3333};
    vecs[5] = '{32'hA000_0000, 1'b0, 6'b000000, 6'b000000, 6'b010000, 6'b000000, 2'b00, 2'b00,
                32'h4444_4444};
    vecs[6] = '{32'hC000_0000, 1'b1, 6'b100000, 6'b000000, 6'b100000, 6'b100000, 2'b01, 2'b00,
                32'h5555_5555};
    vecs[7] = '{32'hF000_0000, 1'b1, 6'b111111, 6'b000000, 6'b000000, 6'b000000, 2'b00, 2'b00,
                32'h0000_0000};
    vecs[8] = '{32'h2000_0000, 1'b1, 6'b000000, 6'b111111, 6'b000000, 6'b000000, 2'b00, 2'b00,
                32'h0000_0000};

    reset   = 1'b1;
    m_adr_i = '0;
    m_dat_i = '0;
    m_sel_i = '0;
    m_we_i  = '0;
    m_cyc_i = '0;
    m_stb_i = '0;
    s_ack_i = '0;
    s_err_i = '0;
    s_dat_i = {32'h5555_5555, 32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111,
               32'hDEAD_BEEF};

    // Reset state
    #2;
    chk("rst_grant", grant_o, 0);
    chk("rst_s_stb", s_stb_o, 0);
    chk("rst_s_cyc", s_cyc_o, 0);
    chk("rst_m_ack", m_ack_o, 0);
    chk("rst_m_err", m_err_o, 0);
    chk("rst_timeout", timeout_o, 0);
    chk("rst_m_dat", m_dat_o, 0);
    chk("rst_s_we", s_we_o, 0);
    @(negedge clk);
    reset = 1'b0;

    // Single master read from slave 0, ack after two cycles
    @(negedge clk);
    m_cyc_i[0] = 1'b1;
    m_stb_i[0] = 1'b1;
    m_adr_i[31:0] = 32'h0000_0010;
    #1 chk("t1_no_grant_yet", grant_o, 0);
    @(negedge clk);
    chk("t1_grant", grant_o, 2'b01);
    chk("t1_s_stb", s_stb_o, 6'b000001);
    chk("t1_no_ack0", m_ack_o, 0);
    @(negedge clk);
    chk("t1_no_ack1", m_ack_o, 0);
    @(negedge clk);
    s_ack_i[0] = 1'b1;
    #1;
    chk("t1_ack", m_ack_o, 2'b01);
    chk("t1_dat", m_dat_o, 32'hDEAD_BEEF);
    @(negedge clk);
    m_cyc_i[0] = 1'b0;
    m_stb_i[0] = 1'b0;
    #1;
    chk("t1_late_ack_dropped", m_ack_o, 0);
    chk("t1_stb_dropped", s_stb_o, 0);
    chk("t1_grant_held", grant_o, 2'b01);
    @(negedge clk);
    s_ack_i = '0;
    chk("t1_grant_released", grant_o, 0);

    // Decode/routing table with master 0 owning the bus
    m_cyc_i[0]     = 1'b1;
    m_dat_i        = {32'hBAD0_BAD0, 32'hCAFE_0001};
    m_sel_i        = 8'h5A;
    m_we_i         = 2'b01;
    @(negedge clk);
    chk("tab_grant", grant_o, 2'b01);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      m_adr_i[31:0] = vecs[i].adr;
      m_stb_i[0]    = vecs[i].stb;
      s_ack_i       = vecs[i].ack;
      s_err_i       = vecs[i].err;
      #2;
      chk($sformatf("tab%0d_s_cyc", i), s_cyc_o, vecs[i].e_cyc);
      chk($sformatf("tab%0d_s_stb", i), s_stb_o, vecs[i].e_stb);
      chk($sformatf("tab%0d_m_ack", i), m_ack_o, vecs[i].e_ack);
      chk($sformatf("tab%0d_m_err", i), m_err_o, vecs[i].e_err);
      chk($sformatf("tab%0d_m_dat", i), m_dat_o, vecs[i].e_dat);
      chk($sformatf("tab%0d_s_adr", i), s_adr_o, vecs[i].adr);
      #1;
      m_stb_i[0] = 1'b0;
      s_ack_i    = '0;
      s_err_i    = '0;
    end
    chk("tab_s_dat", s_dat_o, 32'hCAFE_0001);
    chk("tab_s_sel", s_sel_o, 4'hA);
    chk("tab_s_we", s_we_o, 1'b1);
    @(negedge clk);
    m_cyc_i[0] = 1'b0;
    m_we_i     = '0;
    @(negedge clk);
    chk("tab_release", grant_o, 0);

    // Unmapped write (prefix 3'b111): one ERR, repeat only after stb is re-qualified
    m_cyc_i[0]    = 1'b1;
    m_stb_i[0]    = 1'b1;
    m_we_i[0]     = 1'b1;
    m_adr_i[31:0] = 32'hF000_0000;
    @(negedge clk);
    chk("t3_grant", grant_o, 2'b01);
    chk("t3_no_stb", s_stb_o, 0);
    chk("t3_no_cyc", s_cyc_o, 0);
    chk("t3_err_not_yet", m_err_o, 0);
    @(negedge clk);
    chk("t3_err", m_err_o, 2'b01);
    chk("t3_no_ack", m_ack_o, 0);
    @(negedge clk);
    chk("t3_err_once", m_err_o, 0);
    @(negedge clk);
    chk("t3_err_still_once", m_err_o, 0);
    chk("t3_no_ack2", m_ack_o, 0);
    m_stb_i[0] = 1'b0;
    @(negedge clk);
    m_stb_i[0] = 1'b1;
    @(negedge clk);
    chk("t3_err_requalified", m_err_o, 2'b01);
    m_cyc_i[0] = 1'b0;
    m_stb_i[0] = 1'b0;
    m_we_i     = '0;
    @(negedge clk);
    chk("t3_release", grant_o, 0);

    // Watchdog: slave 3 silent -> forced ERR in the 9th strobed cycle
    m_cyc_i[0]    = 1'b1;
    m_stb_i[0]    = 1'b1;
    m_adr_i[31:0] = 32'h8000_0000;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("t4_no_timeout_c%0d", k), timeout_o, 0);
    end
    @(negedge clk);
    chk("t4_timeout", timeout_o, 1'b1);
    chk("t4_to_err", m_err_o, 2'b01);
    chk("t4_stb_kept", s_stb_o, 6'b001000);
    @(negedge clk);
    chk("t4_timeout_pulse", timeout_o, 0);
    chk("t4_err_pulse", m_err_o, 0);
    m_cyc_i[0] = 1'b0;
    m_stb_i[0] = 1'b0;
    @(negedge clk);
    chk("t4_release", grant_o, 0);
    // Same access, slave acks exactly in the expiry cycle
    m_cyc_i[0] = 1'b1;
    m_stb_i[0] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
    end
    @(negedge clk);
    s_ack_i[3] = 1'b1;
    #1;
    chk("t4_ack_wins_ack", m_ack_o, 2'b01);
    chk("t4_ack_wins_err", m_err_o, 0);
    chk("t4_ack_wins_to", timeout_o, 0);
    @(negedge clk);
    s_ack_i = '0;
    chk("t4_cnt_cleared", timeout_o, 0);
    m_cyc_i[0] = 1'b0;
    m_stb_i[0] = 1'b0;
    @(negedge clk);
    chk("t4_release2", grant_o, 0);

    // Reset in the middle of a slave 2 access
    m_cyc_i[0]    = 1'b1;
    m_stb_i[0]    = 1'b1;
    m_adr_i[31:0] = 32'h6000_0000;
    @(negedge clk);
    chk("t5_grant", grant_o, 2'b01);
    s_ack_i[2] = 1'b1;
    #1;
    chk("t5_ack", m_ack_o, 2'b01);
    chk("t5_stb", s_stb_o, 6'b000100);
    #1 reset = 1'b1;
    #1;
    chk("t5_async_stb", s_stb_o, 0);
    chk("t5_async_grant", grant_o, 0);
    chk("t5_async_ack", m_ack_o, 0);
    chk("t5_async_cyc", s_cyc_o, 0);
    @(negedge clk);
    reset          = 1'b0;
    s_ack_i        = '0;
    m_adr_i[31:0]  = 32'h0000_0010;
    m_adr_i[63:32] = 32'h4000_0000;
    m_cyc_i        = 2'b11;
    m_stb_i        = 2'b11;

    // Fairness: pointer back at NM-1, so master 0 first, then strict alternation
    for (int r = 0; r < 4; r++) begin
      int         own;
      logic [1:0] eg;
      own = r % 2;
      eg  = 2'b01 << own;
      @(negedge clk);
      chk($sformatf("t2_r%0d_grant", r), grant_o, eg);
      chk($sformatf("t2_r%0d_no_ack", r), m_ack_o, 0);
      s_ack_i[own] = 1'b1;
      #1;
      chk($sformatf("t2_r%0d_ack", r), m_ack_o, eg);
      chk($sformatf("t2_r%0d_s_stb", r), s_stb_o, 6'(eg));
      @(negedge clk);
      s_ack_i      = '0;
      m_cyc_i[own] = 1'b0;
      m_stb_i[own] = 1'b0;
      chk($sformatf("t2_r%0d_hold", r), grant_o, eg);
      @(negedge clk);
      chk($sformatf("t2_r%0d_dead", r), grant_o, 0);
      m_cyc_i[own] = 1'b1;
      m_stb_i[own] = 1'b1;
    end

    m_cyc_i = '0;
    m_stb_i = '0;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
